// File: rtl/safe_map_reader.sv
// Block safety map: one bit per block, a row-by-row clear engine, and a 2-stage pixel query pipeline.
// Optional macro SAFE_MAP_BORDER_EN forces queries on border blocks to read as unsafe.
module safe_map_reader #(
   parameter int SCREEN_WIDTH  = 800,
   parameter int SCREEN_HEIGHT = 600,
   parameter int BLOCK_SIZE    = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_clear,
   output logic       o_rdy,
   input  logic       i_wr_valid,
   input  logic [6:0] i_wr_bx,
   input  logic [5:0] i_wr_by,
   input  logic       i_wr_safe,
   input  logic       i_q_valid,
   input  logic [9:0] i_x,
   input  logic [9:0] i_y,
   output logic       o_q_valid,
   output logic       o_is_safe
);

   localparam int         MAP_W    = SCREEN_WIDTH / BLOCK_SIZE;
   localparam int         MAP_H    = SCREEN_HEIGHT / BLOCK_SIZE;
   localparam logic [9:0] SCR_W    = 10'(SCREEN_WIDTH);
   localparam logic [9:0] SCR_H    = 10'(SCREEN_HEIGHT);
   localparam logic [9:0] BLK      = 10'(BLOCK_SIZE);
   localparam logic [6:0] MAP_W_L  = 7'(MAP_W);
   localparam logic [5:0] MAP_H_L  = 6'(MAP_H);
   localparam logic [5:0] LAST_ROW = 6'(MAP_H - 1);

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } state_t;

   state_t           state_r;
   state_t           state_nx_s;
   logic [5:0]       row_r;
   logic [5:0]       row_nx_s;
   logic             rdy_s;
   logic             wr_acc_s;
   logic             wr_pend_r;
   logic [6:0]       wr_bx_r;
   logic [5:0]       wr_by_r;
   logic             wr_safe_r;
   logic             q_ok_s;
   logic [6:0]       x_blk_s;
   logic [5:0]       y_blk_s;
   logic             q1_valid_r;
   logic             q1_ok_r;
   logic [6:0]       q1_bx_r;
   logic [5:0]       q1_by_r;
   logic             map_bit_s;
   logic             border_s;
   logic             q_valid_r;
   logic             is_safe_r;
   logic [MAP_W-1:0] map_r [MAP_H];

   assign rdy_s     = (state_r == ST_IDLE);
   assign o_rdy     = rdy_s;
   assign o_q_valid = q_valid_r;
   assign o_is_safe = is_safe_r;

   // Clear engine state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_CLEAR;
         row_r   <= 6'd0;
      end else begin
         state_r <= state_nx_s;
         row_r   <= row_nx_s;
      end
   end

   // Clear engine next-state: sweep rows 0..last, restart on any clear pulse
   always_comb begin
      state_nx_s = state_r;
      row_nx_s   = row_r;
      case (state_r)
         ST_CLEAR: begin
            if (i_clear) begin
               row_nx_s = 6'd0;
            end else if (row_r == LAST_ROW) begin
               state_nx_s = ST_IDLE;
               row_nx_s   = 6'd0;
            end else begin
               row_nx_s = row_r + 6'd1;
            end
         end
         ST_IDLE: begin
            if (i_clear) begin
               state_nx_s = ST_CLEAR;
               row_nx_s   = 6'd0;
            end else begin
               row_nx_s = 6'd0;
            end
         end
         default: begin
            state_nx_s = ST_CLEAR;
            row_nx_s   = 6'd0;
         end
      endcase
   end

   // Write acceptance and query front-end decode
   always_comb begin
      x_blk_s = 7'(i_x / BLK);
      y_blk_s = 6'(i_y / BLK);
      if (i_wr_valid && rdy_s && (i_wr_bx < MAP_W_L) && (i_wr_by < MAP_H_L)) begin
         wr_acc_s = 1'b1;
      end else begin
         wr_acc_s = 1'b0;
      end
      if (i_q_valid && rdy_s && (i_x < SCR_W) && (i_y < SCR_H)) begin
         q_ok_s = 1'b1;
      end else begin
         q_ok_s = 1'b0;
      end
   end

   // Accepted writes land one cycle late so a same-cycle query still reads the old bit
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_pend_r <= 1'b0;
         wr_bx_r   <= 7'd0;
         wr_by_r   <= 6'd0;
         wr_safe_r <= 1'b0;
      end else begin
         wr_pend_r <= wr_acc_s;
         wr_bx_r   <= i_wr_bx;
         wr_by_r   <= i_wr_by;
         wr_safe_r <= i_wr_safe;
      end
   end

   // Map storage: delayed write, then row clear (clear wins on the same row)
   always_ff @(posedge clk) begin
      if (!rst && wr_pend_r) begin
         map_r[wr_by_r][wr_bx_r] <= wr_safe_r;
      end
      if (!rst && (state_r == ST_CLEAR)) begin
         map_r[row_r] <= '0;
      end
   end

   // Stage-2 lookup and border masking
   always_comb begin
      map_bit_s = map_r[q1_by_r][q1_bx_r];
`ifdef SAFE_MAP_BORDER_EN
      if ((q1_bx_r == 7'd0) || (q1_bx_r == 7'(MAP_W - 1)) ||
          (q1_by_r == 6'd0) || (q1_by_r == LAST_ROW)) begin
         border_s = 1'b1;
      end else begin
         border_s = 1'b0;
      end
`else
      border_s = 1'b0;
`endif
   end

   // Query pipeline; coordinates are zeroed when out of range to keep the lookup in bounds
   always_ff @(posedge clk) begin
      if (rst) begin
         q1_valid_r <= 1'b0;
         q1_ok_r    <= 1'b0;
         q1_bx_r    <= 7'd0;
         q1_by_r    <= 6'd0;
         q_valid_r  <= 1'b0;
         is_safe_r  <= 1'b0;
      end else begin
         q1_valid_r <= i_q_valid;
         q1_ok_r    <= q_ok_s;
         q1_bx_r    <= q_ok_s ? x_blk_s : 7'd0;
         q1_by_r    <= q_ok_s ? y_blk_s : 6'd0;
         q_valid_r  <= q1_valid_r;
         is_safe_r  <= q1_valid_r & q1_ok_r & map_bit_s & ~border_s;
      end
   end

endmodule

// File: tb/tb_safe_map_reader.sv
// Randomized scoreboard bench for safe_map_reader against a whole-map reference model.
module tb_safe_map_reader;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       i_clear = 1'b0;
   logic       o_rdy;
   logic       i_wr_valid = 1'b0;
   logic [6:0] i_wr_bx = 7'd0;
   logic [5:0] i_wr_by = 6'd0;
   logic       i_wr_safe = 1'b0;
   logic       i_q_valid = 1'b0;
   logic [9:0] i_x = 10'd0;
   logic [9:0] i_y = 10'd0;
   logic       o_q_valid;
   logic       o_is_safe;

`ifdef SAFE_MAP_BORDER_EN
   localparam bit BORDER_EN = 1'b1;
`else
   localparam bit BORDER_EN = 1'b0;
`endif

   safe_map_reader dut (
      .clk       (clk),
      .rst       (rst),
      .i_clear   (i_clear),
      .o_rdy     (o_rdy),
      .i_wr_valid(i_wr_valid),
      .i_wr_bx   (i_wr_bx),
      .i_wr_by   (i_wr_by),
      .i_wr_safe (i_wr_safe),
      .i_q_valid (i_q_valid),
      .i_x       (i_x),
      .i_y       (i_y),
      .o_q_valid (o_q_valid),
      .o_is_safe (o_is_safe)
   );

   always #5 clk = ~clk;

   typedef struct {
      int   due;
      logic val;
   } exp_t;

   exp_t exp_q[$];
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   bit   mon_en = 1'b0;
   bit   chk_rdy = 1'b0;
   bit   mdl_map [60][80];
   int   clear_left = 60;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic zero_map();
      foreach (mdl_map[r, c]) mdl_map[r][c] = 1'b0;
   endtask

   // One stimulus cycle: drive inputs, check readiness, push expected result, advance model
   task automatic step(input bit r, input bit c, input bit wv, input int bx, input int by,
                       input bit ws, input bit qv, input int x, input int y);
      bit   rdy_m;
      bit   e;
      exp_t item;
      @(negedge clk);
      #1;
      rst        = r;
      i_clear    = c;
      i_wr_valid = wv;
      i_wr_bx    = 7'(bx);
      i_wr_by    = 6'(by);
      i_wr_safe  = ws;
      i_q_valid  = qv;
      i_x        = 10'(x);
      i_y        = 10'(y);
      rdy_m      = (clear_left == 0);
      if (chk_rdy) begin
         n_chk++;
         if (o_rdy !== rdy_m) begin
            n_fail++;
            $display("FAIL rdy: cycle %0d o_rdy=%b expected %b", cyc, o_rdy, rdy_m);
         end
      end
      if (r) begin
         exp_q.delete();
         zero_map();
         clear_left = 60;
      end else begin
         if (qv) begin
            e = 1'b0;
            if (rdy_m && x < 800 && y < 600) begin
               e = mdl_map[y / 10][x / 10];
               if (BORDER_EN && (x / 10 == 0 || x / 10 == 79 || y / 10 == 0 || y / 10 == 59))
                  e = 1'b0;
            end
            item.due = cyc + 2;
            item.val = e;
            exp_q.push_back(item);
         end
         if (wv && rdy_m && bx < 80 && by < 60) mdl_map[by][bx] = ws;
         if (c) begin
            zero_map();
            clear_left = 60;
         end else if (clear_left > 0) begin
            clear_left--;
         end
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic wr(input int bx, input int by, input bit s);
      step(0, 0, 1, bx, by, s, 0, 0, 0);
   endtask

   task automatic qry(input int x, input int y);
      step(0, 0, 0, 0, 0, 0, 1, x, y);
   endtask

   // Monitor: pop the scoreboard whenever a result appears, flag late or missing results
   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         if (o_q_valid === 1'b1) begin
            n_chk++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_result: cycle %0d o_q_valid=1 with no query outstanding", cyc);
            end else begin
               e = exp_q.pop_front();
               if (e.due != cyc || o_is_safe !== e.val) begin
                  n_fail++;
                  $display("FAIL query_result: cycle %0d got safe=%b, expected safe=%b at cycle %0d",
                           cyc, o_is_safe, e.val, e.due);
               end
            end
         end else begin
            n_chk++;
            if (o_q_valid !== 1'b0 || o_is_safe !== 1'b0) begin
               n_fail++;
               $display("FAIL idle_output: cycle %0d o_q_valid=%b o_is_safe=%b, expected 0 0",
                        cyc, o_q_valid, o_is_safe);
            end
            if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
               e = exp_q.pop_front();
               n_chk++;
               n_fail++;
               $display("FAIL missing_result: cycle %0d no o_q_valid, expected one due at cycle %0d",
                        cyc, e.due);
            end
         end
      end
   end

   initial begin
      bit near;
      int bx, by, x, y;
      for (int k = 0; k < 3; k++) step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      mon_en  = 1'b1;
      chk_rdy = 1'b1;

      // Post-reset clear window with whole-screen queries and ignored writes
      for (int k = 0; k < 64; k++)
         step(0, 0, 1, $urandom_range(0, 79), $urandom_range(0, 59), 1, 1,
              $urandom_range(0, 1023), $urandom_range(0, 1023));
      for (int k = 0; k < 10; k++) qry($urandom_range(0, 799), $urandom_range(0, 599));

      // Same-cycle write and query reads the old value, next cycle sees the new one
      step(0, 0, 1, 5, 7, 1, 1, 50, 70);
      qry(50, 70);
      qry(55, 79);
      qry(60, 79);

      // Off-screen queries and out-of-range writes
      qry(800, 10);
      qry(10, 600);
      qry(799, 599);
      wr(80, 0, 1);
      wr(3, 60, 1);
      for (int k = 0; k < 80; k++) qry(k * 10 + 5, 5);
      qry(35, 599);

      // Border blocks
      wr(0, 0, 1);
      wr(79, 59, 1);
      qry(0, 0);
      qry(795, 595);
      qry(9, 9);

      // Randomized traffic with occasional clears and resets
      for (int k = 0; k < 1500; k++) begin
         near = ($urandom_range(0, 1) == 1);
         bx = near ? $urandom_range(0, 9) : $urandom_range(0, 84);
         by = near ? $urandom_range(0, 9) : $urandom_range(0, 63);
         x  = near ? $urandom_range(0, 99) : $urandom_range(0, 1023);
         y  = near ? $urandom_range(0, 99) : $urandom_range(0, 1023);
         step(($urandom_range(0, 499) == 0), ($urandom_range(0, 199) == 0),
              ($urandom_range(0, 1) == 1), bx, by, ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 3) != 0), x, y);
      end
      idle(70);

      // Clear restarted mid-way keeps o_rdy low for 90 cycles, then everything reads 0
      wr(5, 7, 1);
      wr(40, 30, 1);
      step(0, 1, 0, 0, 0, 0, 0, 0, 0);
      idle(29);
      step(0, 1, 0, 0, 0, 0, 1, 55, 75);
      idle(62);
      qry(55, 75);
      qry(405, 305);
      qry(0, 0);

      // Reset in the middle of in-flight queries
      qry(55, 75);
      step(1, 0, 0, 0, 0, 0, 1, 55, 75);
      idle(65);
      qry(10, 10);
      idle(5);

      n_chk++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/safe_map_reader.md
SAFE_MAP_READER -- requirements
Module: safe_map_reader

Interface
REQ-001 SHALL have parameter SCREEN_WIDTH, default 800, pixel width of the screen.
REQ-002 SHALL have parameter SCREEN_HEIGHT, default 600, pixel height of the screen.
REQ-003 SHALL have parameter BLOCK_SIZE, default 10, block edge in pixels; map is 80x60 blocks at the defaults.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port i_clear  input  1  one-cycle pulse starting a map clear.
REQ-007 SHALL have port o_rdy  output  1  high when not clearing; writes and queries are accepted only while high.
REQ-008 SHALL have port i_wr_valid  input  1  block write strobe from the level generator.
REQ-009 SHALL have port i_wr_bx  input  7  write block column, 0..79.
REQ-010 SHALL have port i_wr_by  input  6  write block row, 0..59.
REQ-011 SHALL have port i_wr_safe  input  1  block value, 1 = safe.
REQ-012 SHALL have port i_q_valid  input  1  pixel query strobe.
REQ-013 SHALL have port i_x  input  10  query pixel column.
REQ-014 SHALL have port i_y  input  10  query pixel row.
REQ-015 SHALL have port o_q_valid  output  1  query result strobe.
REQ-016 SHALL have port o_is_safe  output  1  query result, meaningful only when o_q_valid is high.

Function
REQ-017 SHALL store one bit per block as 60 row words of 80 bits.
REQ-018 SHALL implement states CLEAR and IDLE; o_rdy = (state == IDLE).
REQ-019 In CLEAR, SHALL zero one row per cycle, rows 0..59 in order, then enter IDLE on the cycle after row 59 is cleared (60 cycles in CLEAR).
REQ-020 An i_clear pulse in IDLE SHALL enter CLEAR at row 0 on the next cycle.
REQ-021 An i_clear pulse during CLEAR SHALL restart the clear at row 0.
REQ-022 A write (i_wr_valid while o_rdy) SHALL set bit [i_wr_by][i_wr_bx] to i_wr_safe, visible to queries from the next cycle onward.
REQ-023 SHALL ignore writes with bx > 79 or by > 59, and writes while o_rdy is low.
REQ-024 Queries SHALL use a 2-stage pipeline: stage 1 registers bx = i_x / BLOCK_SIZE, by = i_y / BLOCK_SIZE and an in-range flag; stage 2 registers the looked-up bit.
REQ-025 A query accepted at cycle N SHALL produce o_q_valid = 1 at cycle N+2, one result per query, back-to-back queries at full rate.
REQ-026 Queries with i_x >= SCREEN_WIDTH or i_y >= SCREEN_HEIGHT SHALL return o_is_safe = 0.
REQ-027 i_q_valid while o_rdy is low SHALL still produce o_q_valid at N+2 with o_is_safe = 0.
REQ-028 A write and a query to the same block in the same cycle SHALL return the pre-write value (read-before-write).
REQ-029 SHALL hold o_is_safe at 0 whenever o_q_valid is 0.

Reset
REQ-030 On rst, SHALL enter CLEAR at row 0 with o_rdy = 0, o_q_valid = 0 and o_is_safe = 0, and flush the query pipeline.
REQ-031 rst asserted mid-clear or mid-query SHALL discard all in-flight work and behave exactly as REQ-030.

Configuration
REQ-032 With macro SAFE_MAP_BORDER_EN defined, queries landing in block column 0 or 79, or block row 0 or 59, SHALL return 0 regardless of stored contents; stored bits are still written.
REQ-033 Without SAFE_MAP_BORDER_EN, border blocks SHALL return their stored value like any other block.

Verification
REQ-034 Release rst -> o_rdy = 0 for exactly 60 cycles, then 1; queries over the whole screen all return 0.
REQ-035 Write (bx=5, by=7, safe=1), then query (x=55, y=79) -> o_q_valid and o_is_safe = 1 two cycles after the query; query (x=60, y=79) -> 0.
REQ-036 Write (5,7,1) and query (x=50, y=70) in the same cycle -> 0; repeat the query one cycle later -> 1.
REQ-037 Query (x=800, y=10) and (x=10, y=600) -> 0; write with bx=80 -> no stored bit changes.
REQ-038 i_clear at cycle 0 and again at cycle 30 -> o_rdy low through cycle 90, then high; all earlier writes read back 0.
REQ-039 Write (0,0,1) and (79,59,1), query both -> 1 without SAFE_MAP_BORDER_EN; 0 with it defined.
